// File: rtl/echo_detector.sv
// -----------------------------------------------------------------------------
// echo_detector
//
// Measures echo time-of-flight for each transmit burst from the beamformed
// receive waveform. Each accepted sample is rectified (|x|, with the most
// negative code saturating to the largest positive one) and folded into a
// 2^WINDOW_LOG2-sample moving average that forms the envelope. After a burst,
// detection is suppressed for BLANK_SAMPLES samples to ride out transmit
// ringing. The detector then listens for the first sample whose envelope
// reaches the threshold. It reports that sample's index on tof_out with a
// tof_valid pulse. If sample index TIMEOUT_SAMPLES-1 passes without a
// detection, it pulses timeout instead.
//
// Ports
//   clk           in   system clock
//   rst_n         in   synchronous, active-low reset
//   burst_start   in   one-cycle pulse when the transmitter fires; restarts
//                      the measurement from any state
//   sample_valid  in   one-cycle strobe qualifying sample_in (never asserted
//                      on two consecutive cycles)
//   sample_in     in   signed two's-complement beamformed sample
//   threshold     in   unsigned detection threshold, read on each env strobe
//   envelope_out  out  current moving-average envelope (unsigned)
//   tof_out       out  sample index of the most recent detection
//   tof_valid     out  one-cycle pulse when tof_out is updated
//   timeout       out  one-cycle pulse when listening expires undetected
//   busy          out  high while blanking or listening
// -----------------------------------------------------------------------------
module echo_detector #(
    parameter int DATA_WIDTH      = 16,
    parameter int WINDOW_LOG2     = 3,
    parameter int BLANK_SAMPLES   = 1000,
    parameter int TIMEOUT_SAMPLES = 30000,
    parameter int TOF_WIDTH       = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         burst_start,
    input  logic                         sample_valid,
    input  logic signed [DATA_WIDTH-1:0] sample_in,
    input  logic        [DATA_WIDTH-1:0] threshold,
    output logic        [DATA_WIDTH-1:0] envelope_out,
    output logic        [TOF_WIDTH-1:0]  tof_out,
    output logic                         tof_valid,
    output logic                         timeout,
    output logic                         busy
);

    localparam int DEPTH = 1 << WINDOW_LOG2;
    localparam int SUM_W = DATA_WIDTH + WINDOW_LOG2;

    localparam logic [DATA_WIDTH-1:0] MAG_MAX  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    // Index of the last sample of the blanking window and of the listening
    // window; the FSM moves on when the counter sits on these values.
    localparam logic [TOF_WIDTH-1:0] BLANK_LAST   = TOF_WIDTH'(BLANK_SAMPLES - 1);
    localparam logic [TOF_WIDTH-1:0] TIMEOUT_LAST = TOF_WIDTH'(TIMEOUT_SAMPLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BLANK  = 2'd1,
        LISTEN = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Rectifier
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mag;

    // NOTE: every signal assigned in an always_comb block gets a default at the
    // top so that no path leaves it unassigned, which would infer a latch.
    always_comb begin
        mag = sample_in;
        if (sample_in == MOST_NEG) begin
            // -(-2^(N-1)) does not fit in N bits; clamp to the largest magnitude.
            mag = MAG_MAX;
        end else if (sample_in[DATA_WIDTH-1]) begin
            mag = -sample_in;
        end
    end

    // -------------------------------------------------------------------------
    // Moving-average envelope
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0]  hist [DEPTH];
    logic [WINDOW_LOG2-1:0] wr_ptr;
    logic [SUM_W-1:0]       sum_q;
    logic [SUM_W-1:0]       sum_next;
    logic                   env_strobe;

    // The oldest entry is already part of sum_q, so the subtraction can never
    // underflow; the sum always equals the total of the history buffer.
    assign sum_next = sum_q + SUM_W'(mag) - SUM_W'(hist[wr_ptr]);

    // NOTE: the history buffer is deliberately reset. A restart must empty the
    // window anyway so that the new burst's envelope starts from zero, and the
    // buffer is only a handful of registers.
    // NOTE: state is updated with non-blocking assignments only, so every
    // register samples the values from before the edge regardless of the
    // order of statements.
    always_ff @(posedge clk) begin
        if (!rst_n || burst_start) begin
            for (int i = 0; i < DEPTH; i++) begin
                hist[i] <= '0;
            end
            wr_ptr       <= '0;
            sum_q        <= '0;
            envelope_out <= '0;
            // A sample colliding with burst_start is dropped, so it must not
            // produce an env strobe either.
            env_strobe   <= 1'b0;
        end else begin
            env_strobe <= sample_valid;
            if (sample_valid) begin
                hist[wr_ptr] <= mag;
                wr_ptr       <= wr_ptr + WINDOW_LOG2'(1);
                sum_q        <= sum_next;
                envelope_out <= sum_next[SUM_W-1:WINDOW_LOG2];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Measurement FSM
    //
    // Decisions are taken in the env strobe cycle, when envelope_out already
    // reflects the sample whose index is held in n_q. burst_start overrides
    // everything, including a decision due in the same cycle, so an aborted
    // burst never reports.
    // -------------------------------------------------------------------------
    state_t               state_q;
    state_t               state_next;
    logic [TOF_WIDTH-1:0] n_q;
    logic [TOF_WIDTH-1:0] n_next;
    logic                 tof_load;
    logic                 tof_valid_next;
    logic                 timeout_next;

    always_comb begin
        state_next     = state_q;
        n_next         = n_q;
        tof_load       = 1'b0;
        tof_valid_next = 1'b0;
        timeout_next   = 1'b0;

        if (burst_start) begin
            state_next = BLANK;
            n_next     = '0;
        end else if (env_strobe) begin
            unique case (state_q)
                BLANK: begin
                    n_next = n_q + TOF_WIDTH'(1);
                    if (n_q == BLANK_LAST) begin
                        state_next = LISTEN;
                    end
                end
                LISTEN: begin
                    n_next = n_q + TOF_WIDTH'(1);
                    // Detection is checked first so that it wins over a
                    // timeout on the same sample.
                    if (envelope_out >= threshold) begin
                        tof_load       = 1'b1;
                        tof_valid_next = 1'b1;
                        state_next     = IDLE;
                    end else if (n_q == TIMEOUT_LAST) begin
                        timeout_next = 1'b1;
                        state_next   = IDLE;
                    end
                end
                default: begin
                    // IDLE: the envelope keeps running, but nothing is measured.
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            n_q       <= '0;
            tof_out   <= '0;
            tof_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state_q   <= state_next;
            n_q       <= n_next;
            tof_valid <= tof_valid_next;
            timeout   <= timeout_next;
            if (tof_load) begin
                tof_out <= n_q;
            end
        end
    end

    assign busy = (state_q != IDLE);

endmodule
